// File: rtl/writeback_unit.sv
// Register-file write port: merges execute results with in-order load data and
// keeps a 64-entry pending scoreboard so issue can stall on RAW/WAW hazards.
module writeback_unit #(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_rw,
  input  logic [4:0]  issue_rd,
  input  logic        issue_is_load,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_rw,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic [1:0]  rwin,
  output logic [4:0]  rdin,
  output logic [31:0] dtowrite,
  input  logic [5:0]  query_rs,
  input  logic [5:0]  query_rt,
  output logic        hazard,
  output logic        lq_err
);

  logic [63:0]      pending_r;
  logic [1:0]       lq_rw_r [LQ_DEPTH];
  logic [4:0]       lq_rd_r [LQ_DEPTH];
  logic [LQ_AW-1:0] wr_ptr_r;
  logic [LQ_AW-1:0] rd_ptr_r;
  logic [LQ_AW:0]   lq_cnt_r;
  logic             skid_full_r;
  logic [1:0]       skid_rw_r;
  logic [4:0]       skid_rd_r;
  logic [31:0]      skid_data_r;
  logic [1:0]       rwin_r;
  logic [4:0]       rdin_r;
  logic [31:0]      dtowrite_r;
  logic             lq_err_r;

  logic        issue_eff_s;
  logic [5:0]  issue_id_s;
  logic        lq_full_s;
  logic        lq_empty_s;
  logic        issue_fire_s;
  logic        lq_push_s;
  logic        ex_acc_s;
  logic        mem_pop_s;
  logic        mem_under_s;
  logic        commit_v_s;
  logic [1:0]  commit_rw_s;
  logic [4:0]  commit_rd_s;
  logic [31:0] commit_data_s;
  logic        skid_load_s;
  logic        skid_drain_s;
  logic [63:0] set_mask_s;
  logic [63:0] clr_mask_s;

  // GPR0 is hard-wired, so a GPR write to index 0 is no write at all.
  function automatic logic [1:0] eff_rw(input logic [1:0] rw, input logic [4:0] rd);
    eff_rw = ((rw == 2'b01) && (rd == 5'd0)) ? 2'b00 : rw;
  endfunction

  assign issue_eff_s  = (issue_rw == 2'b10) || ((issue_rw == 2'b01) && (issue_rd != 5'd0));
  assign issue_id_s   = {(issue_rw == 2'b10), issue_rd};
  assign lq_full_s    = (lq_cnt_r == (LQ_AW+1)'(LQ_DEPTH));
  assign lq_empty_s   = (lq_cnt_r == {(LQ_AW+1){1'b0}});
  assign issue_ready  = !(issue_eff_s && pending_r[issue_id_s]) && !(issue_is_load && lq_full_s);
  assign issue_fire_s = issue_valid && issue_ready;
  assign lq_push_s    = issue_fire_s && issue_is_load;
  assign ex_ready     = !skid_full_r;
  assign ex_acc_s     = ex_valid && !skid_full_r;
  assign mem_pop_s    = mem_valid && !lq_empty_s;
  assign mem_under_s  = mem_valid && lq_empty_s;
  assign hazard       = pending_r[query_rs] | pending_r[query_rt];
  assign rwin         = rwin_r;
  assign rdin         = rdin_r;
  assign dtowrite     = dtowrite_r;
  assign lq_err       = lq_err_r;

  assign set_mask_s = (issue_fire_s && issue_eff_s) ? (64'd1 << issue_id_s) : 64'd0;
  assign clr_mask_s = (rwin_r != 2'b00) ? (64'd1 << {(rwin_r == 2'b10), rdin_r}) : 64'd0;

  // Write arbitration: returning load data cannot stall, so it beats the skid and execute.
  always_comb begin
    commit_v_s    = 1'b0;
    commit_rw_s   = 2'b00;
    commit_rd_s   = 5'd0;
    commit_data_s = 32'd0;
    skid_load_s   = 1'b0;
    skid_drain_s  = 1'b0;
    if (mem_pop_s) begin
      commit_v_s    = 1'b1;
      commit_rw_s   = lq_rw_r[rd_ptr_r];
      commit_rd_s   = lq_rd_r[rd_ptr_r];
      commit_data_s = mem_data;
      skid_load_s   = ex_acc_s;
    end else if (skid_full_r) begin
      commit_v_s    = 1'b1;
      commit_rw_s   = skid_rw_r;
      commit_rd_s   = skid_rd_r;
      commit_data_s = skid_data_r;
      skid_drain_s  = 1'b1;
    end else if (ex_acc_s) begin
      commit_v_s    = 1'b1;
      commit_rw_s   = ex_rw;
      commit_rd_s   = ex_rd;
      commit_data_s = ex_data;
    end else begin
      commit_v_s    = 1'b0;
    end
  end

  // Pending scoreboard; a set and a clear never target the same bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_r <= 64'd0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Load queue of destinations awaiting in-order memory data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {LQ_AW{1'b0}};
      rd_ptr_r <= {LQ_AW{1'b0}};
      lq_cnt_r <= {(LQ_AW+1){1'b0}};
      lq_err_r <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rw_r[i] <= 2'b00;
        lq_rd_r[i] <= 5'd0;
      end
    end else begin
      if (lq_push_s) begin
        lq_rw_r[wr_ptr_r] <= issue_rw;
        lq_rd_r[wr_ptr_r] <= issue_rd;
        wr_ptr_r          <= wr_ptr_r + {{(LQ_AW-1){1'b0}}, 1'b1};
      end
      if (mem_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(LQ_AW-1){1'b0}}, 1'b1};
      end
      case ({lq_push_s, mem_pop_s})
        2'b10:   lq_cnt_r <= lq_cnt_r + {{LQ_AW{1'b0}}, 1'b1};
        2'b01:   lq_cnt_r <= lq_cnt_r - {{LQ_AW{1'b0}}, 1'b1};
        default: lq_cnt_r <= lq_cnt_r;
      endcase
      lq_err_r <= lq_err_r | mem_under_s;
    end
  end

  // Skid entry holds an execute result that lost to load data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_full_r <= 1'b0;
      skid_rw_r   <= 2'b00;
      skid_rd_r   <= 5'd0;
      skid_data_r <= 32'd0;
    end else if (skid_load_s) begin
      skid_full_r <= 1'b1;
      skid_rw_r   <= ex_rw;
      skid_rd_r   <= ex_rd;
      skid_data_r <= ex_data;
    end else if (skid_drain_s) begin
      skid_full_r <= 1'b0;
    end else begin
      skid_full_r <= skid_full_r;
    end
  end

  // Register-file write port; index and data hold when nothing commits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rwin_r     <= 2'b00;
      rdin_r     <= 5'd0;
      dtowrite_r <= 32'd0;
    end else if (commit_v_s) begin
      rwin_r     <= eff_rw(commit_rw_s, commit_rd_s);
      rdin_r     <= commit_rd_s;
      dtowrite_r <= commit_data_s;
    end else begin
      rwin_r     <= 2'b00;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a cycle model predicts each register-file
// write and the handshake/hazard outputs; a monitor checks the write port.
module tb_writeback_unit;
  localparam int LQD = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid, issue_ready, issue_is_load;
  logic [1:0]  issue_rw;
  logic [4:0]  issue_rd;
  logic        ex_valid, ex_ready;
  logic [1:0]  ex_rw;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [1:0]  rwin;
  logic [4:0]  rdin;
  logic [31:0] dtowrite;
  logic [5:0]  query_rs, query_rt;
  logic        hazard, lq_err;

  always #5 clk = ~clk;

  writeback_unit #(.LQ_DEPTH(LQD), .LQ_AW(2)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rw(issue_rw),
    .issue_rd(issue_rd), .issue_is_load(issue_is_load),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rw(ex_rw), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .rwin(rwin), .rdin(rdin), .dtowrite(dtowrite),
    .query_rs(query_rs), .query_rt(query_rt), .hazard(hazard), .lq_err(lq_err)
  );

  typedef struct { logic [1:0] rw; logic [4:0] rd; logic [31:0] data; int unsigned cyc; } exp_t;
  typedef struct { logic [1:0] rw; logic [4:0] rd; } dst_t;

  exp_t        exp_q[$];
  dst_t        lq[$];
  bit          pend[64];
  bit          wait_v, err;
  logic [1:0]  w_rw, vis_rw;
  logic [4:0]  w_rd, vis_rd;
  logic [31:0] w_d;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    lq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    wait_v = 1'b0; err = 1'b0;
    vis_rw = 2'b00; vis_rd = 5'd0;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rw = 2'b00; issue_rd = 5'd0; issue_is_load = 1'b0;
    ex_valid = 1'b0; ex_rw = 2'b00; ex_rd = 5'd0; ex_data = 32'd0;
    mem_valid = 1'b0; mem_data = 32'd0; query_rs = 6'd0; query_rt = 6'd0;
  endtask

  // One clock cycle: drive, check the combinational outputs, advance the model.
  task automatic step(input logic iv, input logic [1:0] irw, input logic [4:0] ird, input logic ild,
                      input logic ev, input logic [1:0] erw, input logic [4:0] erd, input logic [31:0] ed,
                      input logic mv, input logic [31:0] md, input logic [5:0] qrs, input logic [5:0] qrt);
    logic eff, rdy, fire, ex_acc, c_v;
    logic [5:0]  idx;
    logic [1:0]  c_rw;
    logic [4:0]  c_rd;
    logic [31:0] c_d;
    dst_t        h;
    exp_t        e;
    @(negedge clk);
    issue_valid = iv; issue_rw = irw; issue_rd = ird; issue_is_load = ild;
    ex_valid = ev; ex_rw = erw; ex_rd = erd; ex_data = ed;
    mem_valid = mv; mem_data = md; query_rs = qrs; query_rt = qrt;
    #1;
    eff = (irw == 2'b10) || ((irw == 2'b01) && (ird != 5'd0));
    idx = {(irw == 2'b10), ird};
    rdy = !(eff && pend[idx]) && !(ild && (lq.size() == LQD));
    chk("issue_ready", 32'(issue_ready), 32'(rdy));
    chk("ex_ready", 32'(ex_ready), 32'(!wait_v));
    chk("hazard", 32'(hazard), 32'(pend[qrs] | pend[qrt]));
    chk("lq_err", 32'(lq_err), 32'(err));
    fire = iv && rdy;
    ex_acc = ev && !wait_v;
    c_v = 1'b0; c_rw = 2'b00; c_rd = 5'd0; c_d = 32'd0;
    if (mv && (lq.size() > 0)) begin
      h = lq.pop_front();
      c_v = 1'b1; c_rw = h.rw; c_rd = h.rd; c_d = md;
      if (ex_acc) begin
        wait_v = 1'b1; w_rw = erw; w_rd = erd; w_d = ed;
      end
    end else begin
      if (mv) err = 1'b1;
      if (wait_v) begin
        c_v = 1'b1; c_rw = w_rw; c_rd = w_rd; c_d = w_d; wait_v = 1'b0;
      end else if (ex_acc) begin
        c_v = 1'b1; c_rw = erw; c_rd = erd; c_d = ed;
      end
    end
    if (fire && ild) begin
      h.rw = irw; h.rd = ird;
      lq.push_back(h);
    end
    if (vis_rw != 2'b00) pend[{(vis_rw == 2'b10), vis_rd}] = 1'b0;
    if (fire && eff) pend[idx] = 1'b1;
    if (!c_v || ((c_rw == 2'b01) && (c_rd == 5'd0))) c_rw = 2'b00;
    vis_rw = c_rw; vis_rd = c_rd;
    if (c_rw != 2'b00) begin
      e.rw = c_rw; e.rd = c_rd; e.data = c_d; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_rwin", 32'(rwin), 32'd0);
    chk("rst_rdin", 32'(rdin), 32'd0);
    chk("rst_dtowrite", dtowrite, 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_lq_err", 32'(lq_err), 32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every write on the port must be the next scoreboard entry, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstn === 1'b1) begin
        if (rwin !== 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("spurious_write", {25'd0, rwin, rdin}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("commit_rw", 32'(rwin), 32'(e.rw));
            chk("commit_rd", 32'(rdin), 32'(e.rd));
            chk("commit_data", dtowrite, e.data);
            chk("commit_cycle", cyc, e.cyc);
          end
        end else if ((exp_q.size() > 0) && (exp_q[0].cyc <= cyc)) begin
          e = exp_q.pop_front();
          chk("missing_write", 32'(rwin), 32'(e.rw));
        end
      end
    end
  end

  initial begin
    logic [1:0] irw, erw;
    idle_inputs();
    model_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_rwin", 32'(rwin), 32'd0);
    chk("init_issue_ready", 32'(issue_ready), 32'd1);
    chk("init_ex_ready", 32'(ex_ready), 32'd1);
    chk("init_lq_err", 32'(lq_err), 32'd0);
    rstn = 1'b1;

    // ALU path to GPR5
    step(1'b1, 2'b01, 5'd5, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0,      1'b0, 32'd0, 6'd5, 6'd0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 2'b01, 5'd5, 32'h1234,   1'b0, 32'd0, 6'd5, 6'd0);
    repeat (2) step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'd5, 6'd0);
    // loads FPR3 then GPR7
    step(1'b1, 2'b10, 5'd3, 1'b1, 1'b0, 2'b00, 5'd0, 32'd0,      1'b0, 32'd0, 6'h23, 6'd7);
    step(1'b1, 2'b01, 5'd7, 1'b1, 1'b0, 2'b00, 5'd0, 32'd0,      1'b0, 32'd0, 6'h23, 6'd7);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0,      1'b1, 32'hA, 6'h23, 6'd7);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0,      1'b1, 32'hB, 6'h23, 6'd7);
    repeat (2) step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'h23, 6'd7);
    // fill the load queue, then a fifth load must stall
    for (int i = 0; i < LQD + 1; i++)
      step(1'b1, 2'b01, 5'(10 + i), 1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'd10, 6'd14);
    for (int i = 0; i < LQD; i++)
      step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 32'(100 + i), 6'd10, 6'd13);
    // collision: mem and ex in the same cycle
    step(1'b1, 2'b01, 5'd20, 1'b1, 1'b0, 2'b00, 5'd0, 32'd0,     1'b0, 32'd0, 6'd20, 6'd21);
    step(1'b1, 2'b01, 5'd21, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0,     1'b0, 32'd0, 6'd20, 6'd21);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 2'b01, 5'd21, 32'hE21,   1'b1, 32'hD20, 6'd20, 6'd21);
    repeat (3) step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'd20, 6'd21);
    // WAW on GPR9: the second issue waits for the first write
    step(1'b1, 2'b01, 5'd9, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0,      1'b0, 32'd0, 6'd9, 6'd0);
    step(1'b1, 2'b01, 5'd9, 1'b0, 1'b1, 2'b01, 5'd9, 32'h9A,     1'b0, 32'd0, 6'd9, 6'd0);
    repeat (3) step(1'b1, 2'b01, 5'd9, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'd9, 6'd0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 2'b01, 5'd9, 32'h9B,     1'b0, 32'd0, 6'd9, 6'd0);
    // GPR0: never pending, never written
    step(1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0,      1'b0, 32'd0, 6'd0, 6'd9);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 2'b01, 5'd0, 32'hDEAD,   1'b0, 32'd0, 6'd0, 6'd9);
    repeat (3) step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'd0, 6'd9);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      irw = 2'($urandom_range(0, 2));
      erw = 2'($urandom_range(0, 2));
      step(1'($urandom_range(0, 1)), irw, 5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) != 0), erw, 5'($urandom_range(0, 7)), $urandom,
           (lq.size() > 0) && ($urandom_range(0, 1) == 1), $urandom,
           {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))},
           {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))});
    end

    // underflow: drain, then mem_valid on an empty queue
    for (int i = 0; i < 16 && lq.size() > 0; i++)
      step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, $urandom, 6'd0, 6'd0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 32'hBAD, 6'd0, 6'd0);
    for (int n = 0; n < 20; n++) begin
      irw = 2'($urandom_range(0, 2));
      step(1'($urandom_range(0, 1)), irw, 5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 1) == 1), 2'b10, 5'($urandom_range(0, 7)), $urandom,
           (lq.size() > 0) && ($urandom_range(0, 1) == 1), $urandom, 6'd0, 6'd0);
    end
    chk("lq_err_sticky", 32'(lq_err), 32'd1);

    // asynchronous reset in the middle of traffic
    async_reset();
    step(1'b1, 2'b01, 5'd5, 1'b0, 1'b1, 2'b01, 5'd5, 32'h55,     1'b0, 32'd0, 6'd5, 6'd0);
    repeat (3) step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 32'd0, 6'd5, 6'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
